// File: rtl/vector_sum_pipe.sv
// vector_sum_pipe
// Pipelined, back-pressured vector reduction for the matrix-multiply datapath.
// Each accepted beat carries DIM elements of W_u bits. The elements are
// registered, then summed by a registered binary adder tree. Tree outputs are
// accumulated until a beat flagged in_last closes the group, and the group
// result is held on out_sum/out_ovf until downstream takes it.
//
// Build option: define VSUM_SIGNED_EN for two's-complement elements. In that
// build, elements are sign-extended and overflow follows the signed rule.
// Without it, elements are unsigned and overflow is the carry out of W_ACC.
//
// Pipeline: input register, then $clog2(DIM) adder stages, then the
// accumulator/output register. A last beat accepted at edge t therefore
// shows out_valid after edge t+L+1.
// One global enable (en) advances every register, so a stalled output
// freezes the whole pipe.

module vector_sum_pipe #(
    parameter int DIM   = 5,
    parameter int W_u   = 8,
    parameter int W_ACC = 16
) (
    input  logic                 clk_sys,
    input  logic                 rst_b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIM*W_u-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W_ACC-1:0]     out_sum,
    output logic                 out_ovf
);

    localparam int L   = $clog2(DIM);
    localparam int NP  = 1 << L;
    localparam int W_T = W_u + L;

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    function automatic logic [W_T-1:0] ext_elem(input logic [W_u-1:0] e);
`ifdef VSUM_SIGNED_EN
        return W_T'($signed(e));
`else
        return W_T'(e);
`endif
    endfunction

    logic [W_T-1:0] leaf_d [NP];
    logic [W_T-1:0] leaf   [NP];
    logic           leaf_vld;
    logic           leaf_lst;

    // Unpack the beat (element 0 in the MSBs), extend, and zero-pad to a power of two
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            leaf_d[i] = '0;
        end
        for (int i = 0; i < DIM; i++) begin
            leaf_d[i] = ext_elem(in_data[(DIM-1-i)*W_u +: W_u]);
        end
    end

    // Input register: captures the extended elements with their valid and last flags
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NP; i++) begin
                leaf[i] <= '0;
            end
            leaf_vld <= 1'b0;
            leaf_lst <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < NP; i++) begin
                leaf[i] <= leaf_d[i];
            end
            leaf_vld <= in_valid;
            leaf_lst <= in_valid && in_last;
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int N = NP >> (k + 1);

        logic [W_T-1:0] src [2*N];
        logic           src_vld;
        logic           src_lst;
        logic [W_T-1:0] node [N];
        logic           vld;
        logic           lst;

        if (k == 0) begin : g_src
            // First tree level reads the input register
            always_comb begin
                for (int i = 0; i < 2*N; i++) begin
                    src[i] = leaf[i];
                end
                src_vld = leaf_vld;
                src_lst = leaf_lst;
            end
        end else begin : g_src
            // Later levels read the previous level's partial sums
            always_comb begin
                for (int i = 0; i < 2*N; i++) begin
                    src[i] = g_stage[k-1].node[i];
                end
                src_vld = g_stage[k-1].vld;
                src_lst = g_stage[k-1].lst;
            end
        end

        // Pairwise add; W_T bits hold the full sum, so no carry is lost
        always_ff @(posedge clk_sys or negedge rst_b) begin
            if (!rst_b) begin
                for (int i = 0; i < N; i++) begin
                    node[i] <= '0;
                end
                vld <= 1'b0;
                lst <= 1'b0;
            end else if (en) begin
                for (int i = 0; i < N; i++) begin
                    node[i] <= src[2*i] + src[2*i+1];
                end
                vld <= src_vld;
                lst <= src_lst;
            end
        end
    end

    logic [W_T-1:0]   p;
    logic             p_vld;
    logic             p_lst;
    logic [W_ACC-1:0] p_ext;
    logic [W_ACC-1:0] acc;
    logic             ovf_acc;
    logic [W_ACC-1:0] sum_nxt;
    logic             ovf_nxt;

    assign p     = g_stage[L-1].node[0];
    assign p_vld = g_stage[L-1].vld;
    assign p_lst = g_stage[L-1].lst;

`ifdef VSUM_SIGNED_EN
    // Signed add: overflow when same-sign operands give a result of the other sign
    always_comb begin
        p_ext   = W_ACC'($signed(p));
        sum_nxt = acc + p_ext;
        ovf_nxt = (acc[W_ACC-1] == p_ext[W_ACC-1]) && (sum_nxt[W_ACC-1] != acc[W_ACC-1]);
    end
`else
    // Unsigned add: overflow is the carry out of W_ACC
    always_comb begin
        p_ext              = W_ACC'(p);
        {ovf_nxt, sum_nxt} = {1'b0, acc} + {1'b0, p_ext};
    end
`endif

    // Accumulate tree outputs; a last beat publishes the group and restarts the accumulator
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (en && p_vld) begin
                if (p_lst) begin
                    out_sum   <= sum_nxt;
                    out_ovf   <= ovf_acc | ovf_nxt;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    ovf_acc   <= 1'b0;
                end else begin
                    acc     <= sum_nxt;
                    ovf_acc <= ovf_acc | ovf_nxt;
                end
            end
        end
    end

endmodule
